// File: rtl/tetris_pkg.sv
// Shared move opcodes and scheduler FSM states for the falling-piece datapath.
// Pure type definitions. It adds no latency and no backpressure.
package tetris_pkg;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_LEFT  = 3'd1,
    OP_RIGHT = 3'd2,
    OP_ROT   = 3'd3,
    OP_DOWN  = 3'd4
  } move_op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READY = 2'd1,
    S_ISSUE = 2'd2,
    S_LOCK  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/das_repeat.sv
// DAS/ARR auto-repeat pulse generator for the currently active horizontal direction.
// rep_pulse is combinational on the en_tick cycle. No backpressure: pulses are fire-and-forget.
module das_repeat #(
  parameter int DAS_DELAY  = 16,
  parameter int ARR_PERIOD = 4,
  parameter int CNT_W      = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_tick,
  input  logic hold,
  input  logic restart,
  output logic rep_pulse
);

  localparam logic [CNT_W-1:0] DAS_MAX  = CNT_W'(DAS_DELAY);
  localparam logic [CNT_W-1:0] ARR_LAST = CNT_W'(ARR_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] das_cnt;
  logic [CNT_W-1:0] arr_cnt;
  logic             das_done;

  assign das_done  = (das_cnt == DAS_MAX);
  // arr_cnt reaching ARR_PERIOD is seen one count early so that it wraps straight to 0
  assign rep_pulse = hold && !restart && en_tick && das_done && (arr_cnt == ARR_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      das_cnt <= '0;
      arr_cnt <= '0;
    end else if (restart || !hold) begin
      das_cnt <= '0;
      arr_cnt <= '0;
    end else if (en_tick) begin
      if (!das_done) begin
        das_cnt <= das_cnt + CNT_ONE;
      end else if (arr_cnt == ARR_LAST) begin
        arr_cnt <= '0;
      end else begin
        arr_cnt <= arr_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/tetris_move_scheduler.sv
// Serialises button, auto-repeat and gravity moves into one valid/ready command stream, and requests a lock when a down move is blocked.
// Latency is 1 cycle from pending flag to cmd_valid. cmd_op is held until cmd_ready, and events that arrive meanwhile stay pending.
module tetris_move_scheduler
  import tetris_pkg::*;
#(
  parameter int DAS_DELAY  = 16,
  parameter int ARR_PERIOD = 4,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_tick,
  input  logic       gravity_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_rotate,
  input  logic       btn_drop,
  input  logic       piece_active,
  output logic       cmd_valid,
  output logic [2:0] cmd_op,
  input  logic       cmd_ready,
  input  logic       cmd_blocked,
  output logic       lock_piece
);

  logic prev_l, prev_r, prev_rot;
  logic press_l, press_r, press_rot;
  logic dir_q, dir_d;
  logic hold_act, hold_oth, switch_dir, restart, rep_pulse;
  logic rot_set, h_set, down_set;

  logic pend_rot, pend_h, pend_dir, pend_down;
  logic clr_rot, clr_h, clr_down, clr_all;

  sched_state_t state_q, state_d;
  move_op_t     op_q, op_d;

  assign press_l   = btn_left & ~prev_l;
  assign press_r   = btn_right & ~prev_r;
  assign press_rot = btn_rotate & ~prev_rot;

  // dir_q: 1 = right. Releasing the active side while the other is held hands over with an immediate move.
  assign hold_act   = dir_q ? btn_right : btn_left;
  assign hold_oth   = dir_q ? btn_left : btn_right;
  assign switch_dir = !hold_act && hold_oth && !press_l && !press_r;
  assign dir_d      = press_r ? 1'b1 : (press_l ? 1'b0 : (switch_dir ? ~dir_q : dir_q));
  assign restart    = press_l | press_r | switch_dir;

  das_repeat #(
    .DAS_DELAY (DAS_DELAY),
    .ARR_PERIOD(ARR_PERIOD),
    .CNT_W     (CNT_W)
  ) u_das (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_tick  (en_tick),
    .hold     (hold_act),
    .restart  (restart),
    .rep_pulse(rep_pulse)
  );

  assign rot_set  = press_rot;
  assign h_set    = restart | rep_pulse;
  assign down_set = gravity_tick | (btn_drop & en_tick);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_l   <= 1'b0;
      prev_r   <= 1'b0;
      prev_rot <= 1'b0;
      dir_q    <= 1'b0;
    end else begin
      prev_l   <= btn_left;
      prev_r   <= btn_right;
      prev_rot <= btn_rotate;
      dir_q    <= dir_d;
    end
  end

  // A new event beats the issue of the same flag; only a flush beats a new event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_rot  <= 1'b0;
      pend_h    <= 1'b0;
      pend_dir  <= 1'b0;
      pend_down <= 1'b0;
    end else if (clr_all) begin
      pend_rot  <= 1'b0;
      pend_h    <= 1'b0;
      pend_down <= 1'b0;
    end else begin
      if (rot_set)      pend_rot <= 1'b1;
      else if (clr_rot) pend_rot <= 1'b0;
      if (h_set) begin
        pend_h   <= 1'b1;
        pend_dir <= dir_d;
      end else if (clr_h) begin
        pend_h <= 1'b0;
      end
      if (down_set)      pend_down <= 1'b1;
      else if (clr_down) pend_down <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_NONE;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    clr_rot  = 1'b0;
    clr_h    = 1'b0;
    clr_down = 1'b0;
    clr_all  = 1'b0;
    if (!piece_active) begin
      state_d = S_IDLE;
      op_d    = OP_NONE;
      clr_all = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_READY;
          op_d    = OP_NONE;
          clr_all = 1'b1;
        end
        S_READY: begin
          op_d = OP_NONE;
          if (pend_rot) begin
            op_d    = OP_ROT;
            clr_rot = 1'b1;
            state_d = S_ISSUE;
          end else if (pend_h) begin
            op_d    = pend_dir ? OP_RIGHT : OP_LEFT;
            clr_h   = 1'b1;
            state_d = S_ISSUE;
          end else if (pend_down) begin
            op_d     = OP_DOWN;
            clr_down = 1'b1;
            state_d  = S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (cmd_ready) begin
            op_d    = OP_NONE;
            state_d = (op_q == OP_DOWN && cmd_blocked) ? S_LOCK : S_READY;
          end
        end
        S_LOCK: begin
          op_d    = OP_NONE;
          clr_all = 1'b1;
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          op_d    = OP_NONE;
          clr_all = 1'b1;
        end
      endcase
    end
  end

  assign cmd_valid  = (state_q == S_ISSUE);
  assign cmd_op     = op_q;
  assign lock_piece = (state_q == S_LOCK);

endmodule

// File: tb/tb_tetris_move_scheduler.sv
// Directed self-checking bench for tetris_move_scheduler (DAS_DELAY=16, ARR_PERIOD=4).
module tb_tetris_move_scheduler;
  import tetris_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en_tick, gravity_tick;
  logic       btn_left, btn_right, btn_rotate, btn_drop;
  logic       piece_active;
  logic       cmd_valid;
  logic [2:0] cmd_op;
  logic       cmd_ready, cmd_blocked;
  logic       lock_piece;

  int total = 0;
  int passed = 0;
  int cyc = 0;
  int ntick = 0;
  int locks = 0;
  logic [2:0] acc_op[$];
  int         acc_tick[$];
  int         acc_cyc[$];

  tetris_move_scheduler #(.DAS_DELAY(16), .ARR_PERIOD(4), .CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_tick     (en_tick),
    .gravity_tick(gravity_tick),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_rotate  (btn_rotate),
    .btn_drop    (btn_drop),
    .piece_active(piece_active),
    .cmd_valid   (cmd_valid),
    .cmd_op      (cmd_op),
    .cmd_ready   (cmd_ready),
    .cmd_blocked (cmd_blocked),
    .lock_piece  (lock_piece)
  );

  always #5 clk = ~clk;

  // Log every accepted command with its cycle and the number of en_ticks seen before it.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_valid && cmd_ready) begin
        acc_op.push_back(cmd_op);
        acc_tick.push_back(ntick);
        acc_cyc.push_back(cyc);
      end
      if (lock_piece) locks++;
      if (en_tick) ntick++;
      cyc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    acc_op.delete();
    acc_tick.delete();
    acc_cyc.delete();
    ntick = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    en_tick = 1'b0; gravity_tick = 1'b0;
    btn_left = 1'b0; btn_right = 1'b0; btn_rotate = 1'b0; btn_drop = 1'b0;
    piece_active = 1'b1;
    cmd_ready = 1'b1; cmd_blocked = 1'b0;
    #12;
    chk("rst_valid", 32'(cmd_valid), 32'(0));
    chk("rst_op", 32'(cmd_op), 32'(OP_NONE));
    chk("rst_lock", 32'(lock_piece), 32'(0));
    rst_n = 1'b1;

    // Idle with a live piece and no inputs
    repeat (6) tick();
    chk("idle_valid", 32'(cmd_valid), 32'(0));
    chk("idle_cmds", 32'(acc_op.size()), 32'(0));
    chk("idle_locks", 32'(locks), 32'(0));

    // Hold left through 30 en_ticks
    clear_log();
    btn_left = 1'b1;
    tick();
    for (int i = 0; i < 30; i++) begin
      repeat (3) tick();
      en_tick = 1'b1;
      tick();
      en_tick = 1'b0;
    end
    btn_left = 1'b0;
    repeat (6) tick();
    chk("das_count", 32'(acc_op.size()), 32'(4));
    begin
      int exp_t[4] = '{0, 20, 24, 28};
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("das_op%0d", i), 32'(acc_op[i]), 32'(OP_LEFT));
        chk($sformatf("das_tick%0d", i), 32'(acc_tick[i]), 32'(exp_t[i]));
      end
    end

    // Rotate, left and gravity in one cycle
    clear_log();
    btn_rotate = 1'b1; btn_left = 1'b1; gravity_tick = 1'b1;
    tick();
    gravity_tick = 1'b0;
    repeat (10) tick();
    btn_rotate = 1'b0; btn_left = 1'b0;
    repeat (3) tick();
    chk("prio_count", 32'(acc_op.size()), 32'(3));
    chk("prio_op0", 32'(acc_op[0]), 32'(OP_ROT));
    chk("prio_op1", 32'(acc_op[1]), 32'(OP_LEFT));
    chk("prio_op2", 32'(acc_op[2]), 32'(OP_DOWN));
    chk("prio_gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'(2));
    chk("prio_gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'(2));

    // Stall an OP_RIGHT for 5 cycles with a gravity tick during the stall
    clear_log();
    cmd_ready = 1'b0;
    btn_right = 1'b1;
    tick();
    btn_right = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall_valid%0d", i), 32'(cmd_valid), 32'(1));
      chk($sformatf("stall_op%0d", i), 32'(cmd_op), 32'(OP_RIGHT));
      gravity_tick = (i == 1);
      tick();
    end
    gravity_tick = 1'b0;
    cmd_ready = 1'b1;
    repeat (6) tick();
    chk("stall_count", 32'(acc_op.size()), 32'(2));
    chk("stall_op_a", 32'(acc_op[0]), 32'(OP_RIGHT));
    chk("stall_op_b", 32'(acc_op[1]), 32'(OP_DOWN));
    chk("stall_gap", 32'(acc_cyc[1] - acc_cyc[0]), 32'(2));

    // Blocked down move locks the piece and discards a pending left
    clear_log();
    locks = 0;
    cmd_ready = 1'b0;
    gravity_tick = 1'b1;
    tick();
    gravity_tick = 1'b0;
    tick();
    btn_left = 1'b1;
    tick();
    btn_left = 1'b0;
    tick();
    chk("blk_valid", 32'(cmd_valid), 32'(1));
    chk("blk_op", 32'(cmd_op), 32'(OP_DOWN));
    cmd_ready = 1'b1; cmd_blocked = 1'b1;
    tick();
    cmd_blocked = 1'b0;
    chk("lock_high", 32'(lock_piece), 32'(1));
    chk("lock_valid", 32'(cmd_valid), 32'(0));
    tick();
    chk("lock_low", 32'(lock_piece), 32'(0));
    repeat (8) tick();
    chk("lock_count", 32'(locks), 32'(1));
    chk("lock_cmds", 32'(acc_op.size()), 32'(1));
    chk("lock_after_valid", 32'(cmd_valid), 32'(0));

    // piece_active falls while OP_ROT is stalled
    clear_log();
    locks = 0;
    cmd_ready = 1'b0;
    btn_rotate = 1'b1;
    tick();
    btn_rotate = 1'b0;
    tick();
    chk("drop_pre_valid", 32'(cmd_valid), 32'(1));
    chk("drop_pre_op", 32'(cmd_op), 32'(OP_ROT));
    piece_active = 1'b0;
    tick();
    chk("drop_valid", 32'(cmd_valid), 32'(0));
    chk("drop_op", 32'(cmd_op), 32'(OP_NONE));
    chk("drop_lock", 32'(lock_piece), 32'(0));
    piece_active = 1'b1;
    repeat (6) tick();
    chk("drop_flush_valid", 32'(cmd_valid), 32'(0));
    chk("drop_locks", 32'(locks), 32'(0));

    // Async reset in the middle of an ISSUE
    btn_rotate = 1'b1;
    tick();
    btn_rotate = 1'b0;
    tick();
    chk("mid_pre_valid", 32'(cmd_valid), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(cmd_valid), 32'(0));
    chk("mid_rst_op", 32'(cmd_op), 32'(OP_NONE));
    chk("mid_rst_lock", 32'(lock_piece), 32'(0));
    rst_n = 1'b1;
    repeat (3) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
